distram_regfile: RTL and testbench
==================================

Name: distram_regfile

Overview:
- Parametrised multi-read-port register file built from LUT distributed RAM; successor to the fixed 32-deep, single-read-port, dual-port distributed RAM wrapper.
- Adds configurable depth, read-port count and bit-level write mask, plus a hardware clear sequencer so the contents are defined after reset.
- Used by CPU register files and small lookup tables in the aq32 core.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 32, number of entries; power of two, >= 2.
- NUM_RD, 2, number of independent asynchronous read ports, >= 1.
- INIT_CLEAR, 1, 1 = run the clear sweep after reset; 0 = start READY with undefined contents.
- AW (localparam), $clog2(DEPTH), address width.

Ports:
- clk  in  1  system clock; all writes and state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- wr_mask  in  WIDTH  per-bit write enable; a bit is written only when wr_en && wr_mask[i].
- rd_addr  in  NUM_RD*AW  packed read addresses; port p uses bits [p*AW +: AW].
- rd_data  out  NUM_RD*WIDTH  packed asynchronous read data; port p uses bits [p*WIDTH +: WIDTH].
- clear_req  in  1  single-cycle request to re-run the clear sweep.
- ready  out  1  high when user writes are accepted and read data is valid.
- wr_dropped  out  1  one-cycle pulse when a user write is discarded during a sweep.

Behaviour:
- The clock is clk. Reset is reset_n: asynchronous, active-low.
- FSM states: CLEAR and READY.
- Reset asserted: state = CLEAR if INIT_CLEAR else READY; sweep counter = 0; ready = 0 (or 1 when INIT_CLEAR = 0); wr_dropped = 0.
- Array contents are not reset by reset_n.
- CLEAR state:
  - Each cycle, write all-ones-mask zero data to address cnt, then increment cnt.
  - On the edge that writes cnt = DEPTH-1, go to READY and clear cnt to 0. The sweep therefore takes exactly DEPTH cycles after reset deasserts.
  - ready rises in the first READY cycle.
- READY state: user writes are committed on the rising edge. New data is visible on every rd_data port combinationally after that edge.
- Reads:
  - rd_data is a combinational function of rd_addr and the array (zero read latency).
  - A read of the address being written in the same cycle returns the old value; there is no forwarding.
- While ready = 0, every rd_data port is forced to 0.
- Writes during a sweep: if wr_en is asserted while state = CLEAR, the write is ignored and wr_dropped is registered high for one cycle.
- clear_req:
  - In READY, clear_req moves the FSM to CLEAR at the next edge with cnt = 0, and ready drops that edge.
  - A user write in the same cycle as clear_req is still committed, then cleared by the sweep.
  - clear_req during CLEAR is ignored; the sweep does not restart.
- Reset mid-sweep restarts the sweep from address 0.
- Storage: NUM_RD replicated banks, each with one write port and one read port. All banks receive identical writes, so all ports always agree.
- Masked write: new = (old & ~mask) | (data & mask), implemented per bit via bank write enables with no read-modify-write cycle.
- Address width is exact (AW bits), so there is no out-of-range case.
- cnt is AW bits wide; the terminal compare is against DEPTH-1 and there is no wrap beyond it.

Decomposition:
- Shared package aq32_mem_pkg holds:
  - the clog2-based address-width helper;
  - the FSM state encoding (ST_CLEAR, ST_READY).
- One sub-module, distram_bank: a single write port, single asynchronous read port, bit-masked distributed RAM, parametrised by WIDTH and DEPTH.
- distram_regfile instantiates distram_bank NUM_RD times in a generate loop and owns the FSM and the write mux (sweep vs user).

Test Plan:
- Reset with INIT_CLEAR=1, DEPTH=32: ready is low for exactly 32 cycles after reset_n rises. Reading all addresses on both ports afterwards returns 0x00000000.
- Write 0xDEADBEEF to addr 5 with mask 0xFFFFFFFF, then a second write to addr 5 of 0x12345678 with mask 0x0000FFFF. Port0 and port1 at addr 5 read 0xDEAD5678.
- Same-cycle write and read of addr 7: the old value is returned that cycle and the new value the next cycle, on both ports.
- wr_en asserted during the clear sweep: wr_dropped pulses once per dropped write, and the targeted address reads 0 after ready rises.
- clear_req while READY together with a write to addr 3: ready drops next cycle, and after DEPTH cycles addr 3 reads 0. A second clear_req mid-sweep does not extend the sweep.
- reset_n pulsed at sweep cycle 10: after release, ready stays low for a full DEPTH cycles. Run with DEPTH=64, NUM_RD=3, WIDTH=8 and check all ports agree on random traffic.

Source files
------------

// File: rtl/aq32_mem_pkg.sv
// rtl/aq32_mem_pkg.sv - shared types and helpers for aq32 distributed-RAM blocks
package aq32_mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } regfile_state_t;

    // Address width for a given depth; never less than one bit.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/distram_bank.sv
// rtl/distram_bank.sv - one-write one-async-read bit-masked distributed RAM bank
module distram_bank #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    localparam int AW = aq32_mem_pkg::addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Per-bit write enables so masked writes need no read-modify-write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (we && wr_mask[i]) begin
                mem[wr_addr][i] <= wr_data[i];
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/distram_regfile.sv
// rtl/distram_regfile.sv - multi-read-port register file with hardware clear sweep
module distram_regfile
    import aq32_mem_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int NUM_RD     = 2,
    parameter int INIT_CLEAR = 1,
    localparam int AW = addr_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [WIDTH-1:0]        wr_mask,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    input  logic                    clear_req,
    output logic                    ready,
    output logic                    wr_dropped
);

    regfile_state_t   state, state_next;
    logic [AW-1:0]    cnt, cnt_next;
    logic             bank_we;
    logic [AW-1:0]    bank_addr;
    logic [WIDTH-1:0] bank_data;
    logic [WIDTH-1:0] bank_mask;

    // State, sweep counter and dropped-write flag; array contents are not reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
            cnt        <= '0;
            wr_dropped <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            wr_dropped <= (state == ST_CLEAR) && wr_en;
        end
    end

    // Sweep walks every address once; clear_req only matters in READY.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_CLEAR: begin
                if (cnt == AW'(DEPTH - 1)) begin
                    state_next = ST_READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + AW'(1);
                end
            end
            ST_READY: begin
                if (clear_req) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    // Write mux: the sweep owns the banks in CLEAR, the user port otherwise.
    always_comb begin
        ready     = (state == ST_READY);
        bank_we   = wr_en;
        bank_addr = wr_addr;
        bank_data = wr_data;
        bank_mask = wr_mask;
        if (state == ST_CLEAR) begin
            bank_we   = 1'b1;
            bank_addr = cnt;
            bank_data = '0;
            bank_mask = '1;
        end
    end

    // One replicated bank per read port; identical writes keep them coherent.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_bank
        logic [WIDTH-1:0] bank_rd;

        distram_bank #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_bank (
            .clk     (clk),
            .we      (bank_we),
            .wr_addr (bank_addr),
            .wr_data (bank_data),
            .wr_mask (bank_mask),
            .rd_addr (rd_addr[p*AW +: AW]),
            .rd_data (bank_rd)
        );

        assign rd_data[p*WIDTH +: WIDTH] = ready ? bank_rd : '0;
    end

endmodule

// File: tb/tb_distram_regfile.sv
// tb/tb_distram_regfile.sv - directed self-checking bench for distram_regfile
module tb_distram_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 32 x 32, two read ports
    logic        a_rst_n, a_wr_en, a_clear_req, a_ready, a_wr_dropped;
    logic [4:0]  a_wr_addr;
    logic [31:0] a_wr_data, a_wr_mask;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;

    // Instance B: 64 x 8, three read ports
    logic        b_rst_n, b_wr_en, b_clear_req, b_ready, b_wr_dropped;
    logic [5:0]  b_wr_addr;
    logic [7:0]  b_wr_data, b_wr_mask;
    logic [17:0] b_rd_addr;
    logic [23:0] b_rd_data;

    int checks = 0;
    int failures = 0;

    distram_regfile #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .INIT_CLEAR(1)) dut_a (
        .clk        (clk),
        .reset_n    (a_rst_n),
        .wr_en      (a_wr_en),
        .wr_addr    (a_wr_addr),
        .wr_data    (a_wr_data),
        .wr_mask    (a_wr_mask),
        .rd_addr    (a_rd_addr),
        .rd_data    (a_rd_data),
        .clear_req  (a_clear_req),
        .ready      (a_ready),
        .wr_dropped (a_wr_dropped)
    );

    distram_regfile #(.WIDTH(8), .DEPTH(64), .NUM_RD(3), .INIT_CLEAR(1)) dut_b (
        .clk        (clk),
        .reset_n    (b_rst_n),
        .wr_en      (b_wr_en),
        .wr_addr    (b_wr_addr),
        .wr_data    (b_wr_data),
        .wr_mask    (b_wr_mask),
        .rd_addr    (b_rd_addr),
        .rd_data    (b_rd_data),
        .clear_req  (b_clear_req),
        .ready      (b_ready),
        .wr_dropped (b_wr_dropped)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic a_write(input logic [4:0] addr, input logic [31:0] data, input logic [31:0] mask);
        a_wr_en   = 1'b1;
        a_wr_addr = addr;
        a_wr_data = data;
        a_wr_mask = mask;
    endtask

    initial begin
        int n;
        int errs;
        logic [7:0] bm [64];
        int ra [3];
        logic [5:0] wa;
        logic [7:0] wd, wm;
        logic       we;

        a_rst_n = 1'b0; a_wr_en = 1'b0; a_clear_req = 1'b0;
        a_wr_addr = '0; a_wr_data = '0; a_wr_mask = '0; a_rd_addr = '0;
        b_rst_n = 1'b0; b_wr_en = 1'b0; b_clear_req = 1'b0;
        b_wr_addr = '0; b_wr_data = '0; b_wr_mask = '0; b_rd_addr = '0;
        for (int i = 0; i < 64; i++) bm[i] = 8'h00;

        repeat (3) tick();
        check("rst_ready", 32'(a_ready), 32'd0);
        check("rst_dropped", 32'(a_wr_dropped), 32'd0);
        check("rst_rd_forced0", a_rd_data[31:0], 32'd0);
        check("rst_rd_forced1", a_rd_data[63:32], 32'd0);

        // Initial sweep, with one user write attempted at sweep cycle 3
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        n = 0;
        while (!a_ready && n < 200) begin
            if (n == 3) a_write(5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            else        a_wr_en = 1'b0;
            tick();
            n++;
            if (n == 4) check("drop_pulse", 32'(a_wr_dropped), 32'd1);
            if (n == 5) check("drop_single", 32'(a_wr_dropped), 32'd0);
        end
        a_wr_en = 1'b0;
        check("init_sweep_len", 32'(n), 32'd32);
        check("ready_after_sweep", 32'(a_ready), 32'd1);

        errs = 0;
        for (int a = 0; a < 32; a++) begin
            a_rd_addr = {5'(31 - a), 5'(a)};
            #1;
            if (a_rd_data !== 64'd0) errs++;
        end
        check("clear_all_zero", 32'(errs), 32'd0);
        a_rd_addr = {5'd9, 5'd9};
        #1;
        check("dropped_addr_zero", a_rd_data[31:0], 32'd0);

        // Full write then masked write to addr 5
        tick();
        a_write(5'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        tick();
        a_write(5'd5, 32'h1234_5678, 32'h0000_FFFF);
        tick();
        a_wr_en = 1'b0;
        a_rd_addr = {5'd5, 5'd5};
        #1;
        check("mask_p0", a_rd_data[31:0], 32'hDEAD_5678);
        check("mask_p1", a_rd_data[63:32], 32'hDEAD_5678);

        // Same-cycle write/read of addr 7: old value now, new value next cycle
        tick();
        a_write(5'd7, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
        tick();
        a_write(5'd7, 32'h5A5A_5A5A, 32'hFFFF_FFFF);
        a_rd_addr = {5'd7, 5'd7};
        #1;
        check("rw_old_p0", a_rd_data[31:0], 32'hA5A5_A5A5);
        check("rw_old_p1", a_rd_data[63:32], 32'hA5A5_A5A5);
        tick();
        a_wr_en = 1'b0;
        #1;
        check("rw_new_p0", a_rd_data[31:0], 32'h5A5A_5A5A);
        check("rw_new_p1", a_rd_data[63:32], 32'h5A5A_5A5A);

        // clear_req with a simultaneous write to addr 3, second request mid-sweep
        tick();
        a_write(5'd3, 32'hCAFE_F00D, 32'hFFFF_FFFF);
        a_clear_req = 1'b1;
        tick();
        a_wr_en = 1'b0;
        a_clear_req = 1'b0;
        check("clr_ready_drop", 32'(a_ready), 32'd0);
        n = 0;
        while (!a_ready && n < 200) begin
            a_clear_req = (n == 10);
            tick();
            n++;
        end
        a_clear_req = 1'b0;
        check("clr_sweep_len", 32'(n), 32'd32);
        a_rd_addr = {5'd5, 5'd3};
        #1;
        check("clr_addr3_zero", a_rd_data[31:0], 32'd0);
        check("clr_addr5_zero", a_rd_data[63:32], 32'd0);

        // Reset pulse at sweep cycle 10 restarts the full sweep
        tick();
        a_clear_req = 1'b1;
        tick();
        a_clear_req = 1'b0;
        repeat (10) tick();
        check("mid_sweep_not_ready", 32'(a_ready), 32'd0);
        a_rst_n = 1'b0;
        #2;
        check("mid_rst_dropped", 32'(a_wr_dropped), 32'd0);
        a_rst_n = 1'b1;
        n = 0;
        while (!a_ready && n < 200) begin
            tick();
            n++;
        end
        check("rst_restart_len", 32'(n), 32'd32);

        // Instance B: sweep length, then random traffic against a model
        b_rst_n = 1'b0;
        #2;
        check("b_rst_ready", 32'(b_ready), 32'd0);
        b_rst_n = 1'b1;
        n = 0;
        while (!b_ready && n < 300) begin
            tick();
            n++;
        end
        check("b_sweep_len", 32'(n), 32'd64);

        for (int it = 0; it < 150; it++) begin
            we = 1'($urandom_range(0, 1));
            wa = 6'($urandom_range(0, 63));
            wd = 8'($urandom);
            wm = 8'($urandom);
            for (int p = 0; p < 3; p++) ra[p] = $urandom_range(0, 63);
            if (it % 5 == 0) ra[it % 3] = int'(wa);
            b_wr_en = we; b_wr_addr = wa; b_wr_data = wd; b_wr_mask = wm;
            b_rd_addr = {6'(ra[2]), 6'(ra[1]), 6'(ra[0])};
            #1;
            for (int p = 0; p < 3; p++) begin
                check($sformatf("b_rd%0d_it%0d", p, it), 32'(b_rd_data[p*8 +: 8]), 32'(bm[ra[p]]));
            end
            tick();
            if (we) bm[wa] = (bm[wa] & ~wm) | (wd & wm);
        end
        b_wr_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
